// File: rtl/pll_lock_seq_pkg.sv
// Shared types and widths for the PLL lock sequencer.
package pll_lock_seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned RETRY_W = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    HOLD      = 3'd2,
    RUN       = 3'd3,
    STDY_RST  = 3'd4
  } state_e;

  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Per-bit multi-flop synchroniser with asynchronous active-low reset.
module pll_lock_sync #(
  parameter int unsigned N      = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [STAGES-1:0][N-1:0] stg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q <= '0;
    end else begin
      stg_q <= {stg_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stg_q[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// Gates the user reset on sustained lock of all enabled PLLs and retries via stdy-reset pulses.
// Optional PLL_LOCK_SEQ_STICKY_EN adds lost_mask and targets the pulse at PLLs that lost lock.
module pll_lock_sequencer
  import pll_lock_seq_pkg::*;
#(
  parameter int unsigned N_PLL           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned HOLD_CYCLES     = 1024,
  parameter int unsigned TIMEOUT_CYCLES  = 65536,
  parameter int unsigned STDY_RST_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_PLL-1:0]   pll_locked,
  input  logic [N_PLL-1:0]   pll_en,
  output logic [N_PLL-1:0]   pll_stdy_rst,
  output logic               user_rst_n,
  output logic               all_locked,
  output logic [STATE_W-1:0] state_o,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOCK_SEQ_STICKY_EN
  ,
  output logic [N_PLL-1:0]   lost_mask
`endif
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned PLS_W = $clog2(STDY_RST_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYCLES - 1);
  localparam logic [PLS_W-1:0] PLS_LAST = PLS_W'(STDY_RST_CYCLES - 1);

  logic [N_PLL-1:0]   lk_sync;
  logic               lock_ok;
  state_e             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic [HLD_W-1:0]   hold_q;
  logic [PLS_W-1:0]   pulse_q;
  logic [N_PLL-1:0]   stdy_q;
  logic               urn_q;
  logic [RETRY_W-1:0] retry_q;
  logic [RETRY_W-1:0] retry_d;
  logic [N_PLL-1:0]   run_mask_d;

  pll_lock_sync #(
    .N      (N_PLL),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (pll_locked),
    .q_o   (lk_sync)
  );

  // Disabled PLLs are forced to "locked"; an all-zero enable therefore reads as locked.
  assign lock_ok = &(lk_sync | ~pll_en);

`ifdef PLL_LOCK_SEQ_STICKY_EN
  logic [N_PLL-1:0] lk_prev_q;
  logic [N_PLL-1:0] lost_q;
  logic [N_PLL-1:0] lost_d;
  logic             watch;

  always_comb begin
    watch      = (state_q == HOLD) || (state_q == RUN);
    lost_d     = lost_q | (lk_prev_q & ~lk_sync & pll_en & {N_PLL{watch}});
    retry_d    = sat_inc(retry_q);
    // lost_d (not lost_q) so a fall seen on the RUN->STDY_RST edge is already targeted.
    run_mask_d = pll_en & lost_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lk_prev_q <= '0;
      lost_q    <= '0;
    end else begin
      lk_prev_q <= lk_sync;
      lost_q    <= lost_d;
    end
  end

  assign lost_mask = lost_q;
`else
  always_comb begin
    retry_d    = sat_inc(retry_q);
    run_mask_d = pll_en;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      hold_q  <= '0;
      pulse_q <= '0;
      stdy_q  <= '0;
      urn_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= WAIT_LOCK;
          timer_q <= '0;
        end
        WAIT_LOCK: begin
          if (lock_ok) begin
            state_q <= HOLD;
            timer_q <= '0;
            hold_q  <= '0;
          end else if (timer_q == TMR_LAST) begin
            state_q <= STDY_RST;
            timer_q <= '0;
            pulse_q <= '0;
            stdy_q  <= pll_en;
            retry_q <= retry_d;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        HOLD: begin
          if (!lock_ok) begin
            state_q <= WAIT_LOCK;
            hold_q  <= '0;
            timer_q <= '0;
          end else if (hold_q == HLD_LAST) begin
            state_q <= RUN;
            hold_q  <= '0;
            urn_q   <= 1'b1;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        RUN: begin
          if (!lock_ok) begin
            state_q <= STDY_RST;
            urn_q   <= 1'b0;
            pulse_q <= '0;
            stdy_q  <= run_mask_d;
            retry_q <= retry_d;
          end
        end
        STDY_RST: begin
          if (pulse_q == PLS_LAST) begin
            state_q <= WAIT_LOCK;
            pulse_q <= '0;
            stdy_q  <= '0;
            timer_q <= '0;
          end else begin
            pulse_q <= pulse_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          urn_q   <= 1'b0;
          stdy_q  <= '0;
        end
      endcase
    end
  end

  assign pll_stdy_rst = stdy_q;
  assign user_rst_n   = urn_q;
  assign all_locked   = urn_q;
  assign state_o      = state_q;
  assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Table-driven scoreboard bench for pll_lock_sequencer (HOLD=16, TIMEOUT=64, pulse=4).
module tb_pll_lock_sequencer;

`ifdef PLL_LOCK_SEQ_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic [7:0]  lk;
    logic [7:0]  en;
    int unsigned cyc;
    logic [2:0]  st;
    logic        urn;
    logic [7:0]  stdy;
    logic [7:0]  retry;
    logic [7:0]  lost;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pll_locked;
  logic [7:0] pll_en;
  logic [7:0] pll_stdy_rst;
  logic       user_rst_n;
  logic       all_locked;
  logic [2:0] state_o;
  logic [7:0] retry_cnt;
`ifdef PLL_LOCK_SEQ_STICKY_EN
  logic [7:0] lost_mask;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .N_PLL           (8),
    .SYNC_STAGES     (2),
    .HOLD_CYCLES     (16),
    .TIMEOUT_CYCLES  (64),
    .STDY_RST_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pll_en       (pll_en),
    .pll_stdy_rst (pll_stdy_rst),
    .user_rst_n   (user_rst_n),
    .all_locked   (all_locked),
    .state_o      (state_o),
    .retry_cnt    (retry_cnt)
`ifdef PLL_LOCK_SEQ_STICKY_EN
    ,
    .lost_mask    (lost_mask)
`endif
  );

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic vec_t mk(input logic r, input logic [7:0] lk, input logic [7:0] en,
                              input int unsigned cyc, input logic [2:0] st, input logic urn,
                              input logic [7:0] sd_all, input logic [7:0] sd_sticky,
                              input logic [7:0] rt, input logic [7:0] lost);
    vec_t v;
    v.rst = r; v.lk = lk; v.en = en; v.cyc = cyc; v.st = st; v.urn = urn;
    v.stdy = STICKY ? sd_sticky : sd_all;
    v.retry = rt; v.lost = lost;
    return v;
  endfunction

  vec_t tbl[24];
  vec_t sb[$];
  vec_t e;
  int   n;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst lk     en     cyc st  urn  stdy   stdy(st) retry lost
    tbl[0]  = mk(0, 8'h00, 8'hFF, 2,  0, 0, 8'h00, 8'h00, 0, 8'h00);
    tbl[1]  = mk(1, 8'h00, 8'hFF, 1,  1, 0, 8'h00, 8'h00, 0, 8'h00);
    tbl[2]  = mk(1, 8'h00, 8'hFF, 49, 1, 0, 8'h00, 8'h00, 0, 8'h00);
    tbl[3]  = mk(1, 8'hFF, 8'hFF, 18, 2, 0, 8'h00, 8'h00, 0, 8'h00);
    tbl[4]  = mk(1, 8'hFF, 8'hFF, 1,  3, 1, 8'h00, 8'h00, 0, 8'h00);
    tbl[5]  = mk(1, 8'hDF, 8'hFF, 2,  3, 1, 8'h00, 8'h00, 0, 8'h00);
    tbl[6]  = mk(1, 8'hDF, 8'hFF, 1,  4, 0, 8'hFF, 8'h20, 1, 8'h20);
    tbl[7]  = mk(1, 8'hDF, 8'hFF, 3,  4, 0, 8'hFF, 8'h20, 1, 8'h20);
    tbl[8]  = mk(1, 8'hDF, 8'hFF, 1,  1, 0, 8'h00, 8'h00, 1, 8'h20);
    tbl[9]  = mk(1, 8'hFF, 8'hFF, 3,  2, 0, 8'h00, 8'h00, 1, 8'h20);
    tbl[10] = mk(1, 8'hFF, 8'hFF, 16, 3, 1, 8'h00, 8'h00, 1, 8'h20);
    tbl[11] = mk(1, 8'h7F, 8'h7F, 5,  3, 1, 8'h00, 8'h00, 1, 8'h20);
    tbl[12] = mk(1, 8'h7F, 8'hFF, 1,  4, 0, 8'hFF, 8'h20, 2, 8'h20);
    tbl[13] = mk(1, 8'h7F, 8'hFF, 4,  1, 0, 8'h00, 8'h00, 2, 8'h20);
    tbl[14] = mk(1, 8'hFF, 8'hFF, 3,  2, 0, 8'h00, 8'h00, 2, 8'h20);
    tbl[15] = mk(1, 8'hFF, 8'hFF, 10, 2, 0, 8'h00, 8'h00, 2, 8'h20);
    tbl[16] = mk(1, 8'hF7, 8'hFF, 2,  2, 0, 8'h00, 8'h00, 2, 8'h20);
    tbl[17] = mk(1, 8'hF7, 8'hFF, 1,  1, 0, 8'h00, 8'h00, 2, 8'h28);
    tbl[18] = mk(1, 8'hFF, 8'hFF, 2,  1, 0, 8'h00, 8'h00, 2, 8'h28);
    tbl[19] = mk(1, 8'hFF, 8'hFF, 1,  2, 0, 8'h00, 8'h00, 2, 8'h28);
    tbl[20] = mk(1, 8'hFF, 8'hFF, 15, 2, 0, 8'h00, 8'h00, 2, 8'h28);
    tbl[21] = mk(1, 8'hFF, 8'hFF, 1,  3, 1, 8'h00, 8'h00, 2, 8'h28);
    tbl[22] = mk(1, 8'h00, 8'hFF, 3,  4, 0, 8'hFF, 8'hFF, 3, 8'hFF);
    tbl[23] = mk(1, 8'h00, 8'hFF, 1,  4, 0, 8'hFF, 8'hFF, 3, 8'hFF);

    for (int i = 0; i < 24; i++) begin
      rst        = tbl[i].rst;
      pll_locked = tbl[i].lk;
      pll_en     = tbl[i].en;
      sb.push_back(tbl[i]);
      repeat (tbl[i].cyc) @(negedge clk);
      e = sb.pop_front();
      check($sformatf("v%0d_state", i), 32'(state_o), 32'(e.st));
      check($sformatf("v%0d_user_rst_n", i), 32'(user_rst_n), 32'(e.urn));
      check($sformatf("v%0d_all_locked", i), 32'(all_locked), 32'(e.urn));
      check($sformatf("v%0d_stdy_rst", i), 32'(pll_stdy_rst), 32'(e.stdy));
      check($sformatf("v%0d_retry", i), 32'(retry_cnt), 32'(e.retry));
`ifdef PLL_LOCK_SEQ_STICKY_EN
      check($sformatf("v%0d_lost_mask", i), 32'(lost_mask), 32'(e.lost));
`endif
    end

    // Second cycle of STDY_RST: reset must clear everything without a clock edge.
    #2 rst = 1'b0;
    #1;
    check("async_rst_stdy", 32'(pll_stdy_rst), 32'h0);
    check("async_rst_state", 32'(state_o), 32'h0);
    check("async_rst_retry", 32'(retry_cnt), 32'h0);
    check("async_rst_urn", 32'(user_rst_n), 32'h0);
`ifdef PLL_LOCK_SEQ_STICKY_EN
    check("async_rst_lost", 32'(lost_mask), 32'h0);
`endif

    // Never lock: timeout retries every 64+4 cycles, retry count saturates.
    pll_locked = 8'h00;
    pll_en     = 8'hFF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (state_o != 3'd4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("first_timeout_edges", 32'(n), 32'd65);
    check("first_timeout_stdy", 32'(pll_stdy_rst), 32'hFF);
    check("first_timeout_retry", 32'(retry_cnt), 32'd1);
    n = 0;
    while (state_o == 3'd4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pulse_width", 32'(n), 32'd4);
    check("pulse_off", 32'(pll_stdy_rst), 32'h0);
    n = 0;
    while (state_o != 3'd4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("retry_wait_cycles", 32'(n), 32'd64);
    check("second_timeout_retry", 32'(retry_cnt), 32'd2);
    repeat (68 * 252) @(negedge clk);
    check("timeout254_state", 32'(state_o), 32'd4);
    check("timeout254_retry", 32'(retry_cnt), 32'd254);
    repeat (68) @(negedge clk);
    check("timeout255_retry", 32'(retry_cnt), 32'd255);
    repeat (136) @(negedge clk);
    check("timeout257_state", 32'(state_o), 32'd4);
    check("retry_saturated", 32'(retry_cnt), 32'd255);
    check("timeout257_stdy", 32'(pll_stdy_rst), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
